// File: rtl/seq_mul_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_param
// Description : Radix-2 shift-add sequential multiplier, WIDTH-bit operands,
//               signed/unsigned selectable per operation, start/ready handshake.
//               Optional macro MUL_ZERO_BYPASS_EN: zero operand finishes at once.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int               c_PW   = 2 * WIDTH;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state,   w_state_nxt;
  logic [c_PW-1:0]    r_mcand,   w_mcand_nxt;
  logic [WIDTH-1:0]   r_mplier,  w_mplier_nxt;
  logic               r_signed,  w_signed_nxt;
  logic [c_PW-1:0]    r_acc,     w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
  logic [c_PW-1:0]    r_product, w_product_nxt;

  logic [c_PW-1:0]    w_a_ext;
  logic [c_PW-1:0]    w_pp;
  logic [c_PW-1:0]    w_acc_upd;
  logic               w_last;

  assign w_a_ext = signed_mode ? {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand}
                               : {{WIDTH{1'b0}}, multiplicand};

  // r_mcand is pre-shifted each cycle, so w_pp is A * 2^i for the current bit.
  assign w_pp      = r_mplier[0] ? r_mcand : '0;
  assign w_last    = (r_cnt == c_LAST);
  assign w_acc_upd = (r_signed && w_last) ? (r_acc - w_pp) : (r_acc + w_pp);

  always_comb begin
    w_state_nxt   = r_state;
    w_mcand_nxt   = r_mcand;
    w_mplier_nxt  = r_mplier;
    w_signed_nxt  = r_signed;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_mcand_nxt  = w_a_ext;
          w_mplier_nxt = multiplier;
          w_signed_nxt = signed_mode;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_CALC;
`ifdef MUL_ZERO_BYPASS_EN
          if ((multiplicand == '0) || (multiplier == '0)) begin
            w_state_nxt   = S_DONE;
            w_product_nxt = '0;
          end
`endif
        end
      end
      S_CALC: begin
        w_acc_nxt    = w_acc_upd;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + c_ONE;
        if (w_last) begin
          w_product_nxt = w_acc_upd;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_signed  <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mcand   <= w_mcand_nxt;
      r_mplier  <= w_mplier_nxt;
      r_signed  <= w_signed_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_product <= w_product_nxt;
    end
  end

  assign busy    = (r_state == S_CALC);
  assign ready   = (r_state == S_DONE);
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mul_param
// Description : Self-checking bench for seq_mul_param (WIDTH=16 and WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mul_param;

`ifdef MUL_ZERO_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  logic        clk, rst, start, sm;
  logic [15:0] a, b;
  logic        busy, ready;
  logic [31:0] prod;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, ready8;
  logic [15:0] prod8;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_start;
  logic [63:0] sb_q[$];

  seq_mul_param #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
    .multiplicand(a), .multiplier(b),
    .busy(busy), .ready(ready), .product(prod)
  );

  seq_mul_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .ready(ready8), .product(prod8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product: operands extended per mode, multiplied modulo 2^(2w).
  function automatic logic [63:0] model(input int w, input bit s,
                                        input logic [63:0] av, input logic [63:0] bv);
    logic [63:0] m, x, y, pm;
    m  = (64'd1 << w) - 64'd1;
    pm = (64'd1 << (2 * w)) - 64'd1;
    x  = av & m;
    y  = bv & m;
    if (s && x[w-1]) x = x | ~m;
    if (s && y[w-1]) y = y | ~m;
    return (x * y) & pm;
  endfunction

  // Drive one start edge, push the expected product, check the state after it.
  task automatic launch(input bit s, input logic [15:0] av, input logic [15:0] bv);
    bit byp;
    byp = c_BYP && ((av == 16'd0) || (bv == 16'd0));
    @(negedge clk);
    sm = s; a = av; b = bv; start = 1'b1;
    sb_q.push_back(model(16, s, {48'd0, av}, {48'd0, bv}));
    @(posedge clk);
    #1;
    t_start = cyc;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    sm = ~s;
    check("busy_after_start", {63'd0, busy}, {63'd0, !byp});
    check("ready_after_start", {63'd0, ready}, {63'd0, byp});
  endtask

  // Wait for ready (bounded), then compare latency in edges after start and product.
  task automatic wait_result(input string tag, input int exp_lat);
    logic [63:0] exp_p;
    int guard;
    guard = 0;
    while (!ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard = guard + 1;
    end
    check({tag, "_ready"}, {63'd0, ready}, 64'd1);
    check({tag, "_latency"}, 64'(cyc - t_start), 64'(exp_lat));
    check({tag, "_excl"}, {63'd0, busy & ready}, 64'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      exp_p = sb_q.pop_front();
      check({tag, "_product"}, {32'd0, prod}, exp_p);
    end
  endtask

  initial begin
    int guard;
    rst = 1'b0; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_product", {32'd0, prod}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic signed multiply, then hold with start low.
    launch(1'b1, 16'd10, 16'd20);
    wait_result("basic", 16);
    repeat (5) @(posedge clk);
    #1;
    check("hold_ready", {63'd0, ready}, 64'd1);
    check("hold_product", {32'd0, prod}, 64'h0000_00C8);

    // Signed and unsigned corner values.
    launch(1'b1, 16'hFFFF, 16'hFFFF); wait_result("s_m1xm1", 16);
    launch(1'b1, 16'h8000, 16'h8000); wait_result("s_minxmin", 16);
    launch(1'b1, 16'h8000, 16'h7FFF); wait_result("s_minxmax", 16);
    launch(1'b0, 16'hFFFF, 16'hFFFF); wait_result("u_maxxmax", 16);
    launch(1'b0, 16'h8000, 16'h0002); wait_result("u_msbx2", 16);
    check("u_msbx2_const", {32'd0, prod}, 64'h0001_0000);

    // Start while busy must be ignored.
    launch(1'b1, 16'd3, 16'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 16'd7; b = 16'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_result("ignored_start", 16);
    check("ignored_const", {32'd0, prod}, 64'd15);

    // Restart from DONE: ready drops, old product held until new result.
    launch(1'b1, 16'd7, 16'd7);
    check("restart_old_product", {32'd0, prod}, 64'd15);
    wait_result("restart", 16);
    check("restart_const", {32'd0, prod}, 64'd49);

    // Asynchronous reset mid-operation.
    launch(1'b1, 16'd9, 16'd9);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_ready", {63'd0, ready}, 64'd0);
    check("midrst_product", {32'd0, prod}, 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    launch(1'b1, 16'd2, 16'd3);
    wait_result("after_rst", 16);

    // Zero operand: bypass or full-length path depending on build.
    launch(1'b1, 16'd0, 16'h1234);
    wait_result("zero_op", c_BYP ? 0 : 16);

    // WIDTH=8 instance: signed -128 * -1.
    @(negedge clk);
    sm8 = 1'b1; a8 = 8'h80; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    t_start = cyc;
    guard = 0;
    while (!ready8 && guard < 100) begin
      @(posedge clk);
      #1;
      guard = guard + 1;
    end
    check("w8_ready", {63'd0, ready8}, 64'd1);
    check("w8_latency", 64'(cyc - t_start), 64'd8);
    check("w8_product", {48'd0, prod8}, model(8, 1'b1, 64'h80, 64'hFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_mul_param.md
Name: seq_mul_param

Overview:
Parametrised radix-2 shift-add sequential multiplier, successor to the fixed 16x16 signed sequential multiplier. Operand width is a parameter, and a per-operation mode input selects signed (two's complement) or unsigned operation. A busy flag and start-while-busy rejection are added. The block sits in the datapath as a low-area multi-cycle multiplier driven by a start/ready handshake.

Parameters:
WIDTH, 16, operand width in bits (legal 4..64); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration-counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock; single clock domain.
rst  input  1  asynchronous, active-low reset.
start  input  1  request; sampled on the rising edge of clk.
signed_mode  input  1  1 = both operands two's complement, 0 = both unsigned; latched with start.
multiplicand  input  WIDTH  operand A; latched with start.
multiplier  input  WIDTH  operand B; latched with start.
busy  output  1  high while iterating.
ready  output  1  high while product holds a valid result.
product  output  2*WIDTH  result; held stable while ready=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - busy=0, ready=0, product=0, counter=0.
  - All operand registers cleared.
  - Reset takes effect immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE, CALC, DONE.
- IDLE: on an edge with start=1:
  - latch A, B and signed_mode; clear the accumulator.
  - counter=0; go to CALC; busy=1 after that edge.
- CALC: one multiplier bit per edge, LSB first.
  - Bit i of B = 1: add A, extended to 2*WIDTH (sign-extended if signed_mode=1, else zero-extended), shifted left by i.
  - Exception: for i = WIDTH-1 with signed_mode=1, SUBTRACT that partial product instead (MSB carries negative weight).
  - All arithmetic is modulo 2^(2*WIDTH).
  - Exactly WIDTH CALC edges. On the WIDTH-th edge: product = final accumulator, busy=0, ready=1, state=DONE.
- Latency: ready rises exactly WIDTH clock cycles after the edge that sampled start (16 cycles at default).
- DONE:
  - product and ready held indefinitely.
  - start=1 on an edge: latch new operands, go to CALC, ready=0 and busy=1 after that edge. The product register keeps its old value until the new result is written.
- start=1 while busy=1 is ignored: no relatch, no restart, latency unaffected.
- Operand inputs may change freely after the start edge; only the latched copies are used.
- Range: full signed range is exact, e.g. (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2), no overflow. Full unsigned range is exact.
- busy and ready are never both 1.

Optional Feature:
MUL_ZERO_BYPASS_EN
- Defined: if either latched operand is 0 at the start edge, skip CALC and go directly to DONE. product=0 and ready=1 after exactly 1 cycle; busy stays 0.
- Undefined: zero operands take the full WIDTH-cycle path like any other operands (product=0 after WIDTH cycles).

Test Plan:
1. WIDTH=16, signed_mode=1, A=10, B=20, start pulse -> busy=1 for 16 cycles; ready=1 exactly 16 cycles after the start edge; product=0x000000C8; held while start=0.
2. signed_mode=1: A=0xFFFF(-1), B=0xFFFF -> product=0x00000001. A=0x8000, B=0x8000 -> 0x40000000. A=0x8000, B=0x7FFF -> 0xC0008000.
3. signed_mode=0: A=0xFFFF, B=0xFFFF -> product=0xFFFE0001. A=0x8000, B=0x0002 -> 0x00010000.
4. Start A=3, B=5; at cycle 5 pulse start with A=7, B=7 -> second start ignored; product=15 at cycle 16. Then start from DONE with A=7, B=7 -> ready drops next edge; product=49 after 16 cycles.
5. Assert rst=0 mid-CALC (cycle 8) -> busy, ready, product go to 0 immediately, without a clock edge. Release and start A=2, B=3 -> product=6 after 16 cycles.
6. A=0, B=0x1234:
   - MUL_ZERO_BYPASS_EN defined: ready after 1 cycle, product=0.
   - Undefined: ready after 16 cycles, product=0.
   - Also: WIDTH=8 build, signed, A=0x80, B=0xFF -> product=0x0080 after 8 cycles.
